// File: rtl/common_tcam_entry_store.sv
// Tag/valid storage feeding the coupling TCAM: allocates into the lowest free
// entry, or replaces a round-robin victim when full and reports the evicted tag.
module common_tcam_entry_store #(
    parameter  int CAM_DEPTH  = 4,
    parameter  int CAM_WIDTH  = 8,
    localparam int ADDR_WIDTH = $clog2(CAM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_alloc_valid,
    input  logic [CAM_WIDTH-1:0]           i_alloc_data,
    output logic                           o_alloc_ready,
    output logic [ADDR_WIDTH-1:0]          o_alloc_addr,
    input  logic                           i_inv_valid,
    input  logic [ADDR_WIDTH-1:0]          i_inv_addr,
    input  logic                           i_flush,
    output logic                           o_evict_valid,
    output logic [ADDR_WIDTH-1:0]          o_evict_addr,
    output logic [CAM_WIDTH-1:0]           o_evict_data,
    output logic [CAM_DEPTH*CAM_WIDTH-1:0] tdata,
    output logic [CAM_DEPTH-1:0]           dvalid,
    output logic [ADDR_WIDTH:0]            o_count,
    output logic                           o_full
);

    logic [CAM_WIDTH-1:0]  entry [CAM_DEPTH];
    logic [CAM_DEPTH-1:0]  valid;
    logic [CAM_DEPTH-1:0]  valid_nxt;
    logic [ADDR_WIDTH-1:0] vptr;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  accept;
    logic                  target_hit;

    assign o_alloc_ready = !i_flush;
    assign accept        = i_alloc_valid && !i_flush;

    // Lowest-index free entry wins; the victim pointer is used only when full.
    always_comb begin
        target = vptr;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                target = ADDR_WIDTH'(i);
            end
        end
    end

    assign target_hit   = valid[target];
    assign o_alloc_addr = target;

    // Allocation overrides an invalidate to the same index; flush overrides all.
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (i_inv_valid && (i_inv_addr == ADDR_WIDTH'(i))) begin
                valid_nxt[i] = 1'b0;
            end
        end
        if (accept) begin
            valid_nxt[target] = 1'b1;
        end
        if (i_flush) begin
            valid_nxt = '0;
        end
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            count_nxt = count_nxt + (ADDR_WIDTH + 1)'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid   <= '0;
            o_count <= '0;
            o_full  <= 1'b0;
        end else begin
            valid   <= valid_nxt;
            o_count <= count_nxt;
            o_full  <= (count_nxt == (ADDR_WIDTH + 1)'(CAM_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CAM_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CAM_DEPTH; i++) begin
                if (accept && (target == ADDR_WIDTH'(i))) begin
                    entry[i] <= i_alloc_data;
                end
            end
        end
    end

    // Eviction address/data hold after the pulse so they can be read late.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vptr          <= '0;
            o_evict_valid <= 1'b0;
            o_evict_addr  <= '0;
            o_evict_data  <= '0;
        end else begin
            o_evict_valid <= accept && target_hit;
            if (accept && target_hit) begin
                o_evict_addr <= target;
                o_evict_data <= entry[target];
                if (vptr == ADDR_WIDTH'(CAM_DEPTH - 1)) begin
                    vptr <= '0;
                end else begin
                    vptr <= vptr + 1'b1;
                end
            end
        end
    end

    assign dvalid = valid;

    for (genvar g = 0; g < CAM_DEPTH; g++) begin : g_tdata
        assign tdata[CAM_WIDTH*g +: CAM_WIDTH] = entry[g];
    end

endmodule
